// File: rtl/sub_byte_serial_seq.sv
// Byte-serial sequencer for wide A - B - bin on an external 8-bit subtractor.
// Feeds one byte per cycle LSB first, chains the borrow, returns the result over valid/ready.
module sub_byte_serial_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_a,
  input  logic [8*NBYTES-1:0] in_b,
  input  logic                in_bin,
  output logic [7:0]          sub_a,
  output logic [7:0]          sub_b,
  output logic                sub_bin,
  input  logic [7:0]          sub_diff,
  input  logic                sub_bout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_diff,
  output logic                out_bout,
  output logic                out_zero
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_s;
  logic [IW-1:0]   idx_r;
  logic [W-1:0]    a_r;
  logic [W-1:0]    b_r;
  logic            bin_r;
  logic            borrow_r;
  logic [W-1:0]    diff_r;
  logic [W-1:0]    diff_s;
  logic            last_s;

  assign last_s = (idx_r == LAST_IDX);

  // Next-state decode for the job sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_ready) state_s = RUN;
        else                      state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (out_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // Operand byte selection and the difference word with the current byte merged in
  always_comb begin
    sub_a   = 8'h00;
    sub_b   = 8'h00;
    sub_bin = 1'b0;
    diff_s  = diff_r;
    if (state_r == RUN) begin
      sub_a   = a_r[8*idx_r +: 8];
      sub_b   = b_r[8*idx_r +: 8];
      sub_bin = (idx_r == {IW{1'b0}}) ? bin_r : borrow_r;
      diff_s[8*idx_r +: 8] = sub_diff;
    end else begin
      sub_a   = 8'h00;
      sub_b   = 8'h00;
      sub_bin = 1'b0;
    end
  end

  // State register with handshake flags registered from the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_r   <= state_s;
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
    end
  end

  // Operand capture, byte stepping and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_r    <= {IW{1'b0}};
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      bin_r    <= 1'b0;
      borrow_r <= 1'b0;
      diff_r   <= {W{1'b0}};
      out_diff <= {W{1'b0}};
      out_bout <= 1'b0;
      out_zero <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_r      <= in_a;
            b_r      <= in_b;
            bin_r    <= in_bin;
            idx_r    <= {IW{1'b0}};
            borrow_r <= 1'b0;
            diff_r   <= {W{1'b0}};
          end
        end
        RUN: begin
          diff_r   <= diff_s;
          borrow_r <= sub_bout;
          if (last_s) begin
            // diff_s already holds the final byte, so zero detect sees the full word
            idx_r    <= {IW{1'b0}};
            out_diff <= diff_s;
            out_bout <= sub_bout;
            out_zero <= (diff_s == {W{1'b0}});
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        default: begin
          idx_r <= idx_r;
        end
      endcase
    end
  end

endmodule
